// File: rtl/accel_cr_responder_pkg.sv
// Shared definitions for the accel CR-space responder: region bounds, CR
// offsets, control/status bit positions, multiplier packet and FSM types.
package accel_cr_responder_pkg;

  localparam logic [31:0] CR_MEM_REGION_FLOOR = 32'h00FE_0000;
  localparam logic [31:0] CR_MEM_REGION_ROOF  = 32'h00FE_FFFF;

  localparam logic [31:0] CR_XOR_INP1   = 32'h00FE_0000; // CR_0
  localparam logic [31:0] CR_XOR_INP2   = 32'h00FE_0004; // CR_1
  localparam logic [31:0] CR_XOR_RESULT = 32'h00FE_0008; // CR_2 (RO)
  localparam logic [31:0] CR_MUL_MCAND  = 32'h00FE_000C; // CR_3
  localparam logic [31:0] CR_MUL_MPLIER = 32'h00FE_0010; // CR_4
  localparam logic [31:0] CR_MUL_CTRL   = 32'h00FE_0014; // CR_5
  localparam logic [31:0] CR_MUL_RESULT = 32'h00FE_0018; // CR_6 (RO)

  // CR_5 write bits
  localparam int CR5_START_BIT    = 0;
  localparam int CR5_CLR_DONE_BIT = 1;
  // CR_5 read bits
  localparam int CR5_BUSY_BIT     = 0;
  localparam int CR5_DONE_BIT     = 1;
  localparam int CR5_TIMEOUT_BIT  = 2;
  // CR_6 field
  localparam int CR6_RESULT_LSB   = 0;
  localparam int CR6_RESULT_MSB   = 15;

  typedef struct packed {
    logic [16:0] AQQ_0;
    logic [7:0]  Mu;
  } stage_mul_inp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } t_mul_state;

  typedef struct packed {
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic [15:0] result;
    logic        done;
    logic        timeout;
  } t_mul_cr;

endpackage

// File: rtl/accel_cr_responder_if.sv
// Core request/response port plus the multiplier start/done handshake.
// master = core and multiplier side, slave = CR responder.
interface accel_cr_responder_if;
  import accel_cr_responder_pkg::*;

  logic           ReqValid;
  logic           ReqWrEn;
  logic [31:0]    ReqAddr;
  logic [31:0]    ReqWrData;
  logic           RspValid;
  logic [31:0]    RspData;
  logic           MulStartValid;
  logic           MulStartReady;
  stage_mul_inp_t MulInp;
  logic           MulDoneValid;
  logic [15:0]    MulResult;

  modport master (
    output ReqValid, ReqWrEn, ReqAddr, ReqWrData, MulStartReady, MulDoneValid, MulResult,
    input  RspValid, RspData, MulStartValid, MulInp
  );

  modport slave (
    input  ReqValid, ReqWrEn, ReqAddr, ReqWrData, MulStartReady, MulDoneValid, MulResult,
    output RspValid, RspData, MulStartValid, MulInp
  );

endinterface

// File: rtl/accel_cr_mul_seq.sv
// Multiplier sequencer: IDLE/REQ/WAIT handshake FSM, operand snapshot and,
// when ACCEL_CR_TIMEOUT_EN is defined, an 8-bit WAIT-state watchdog.
module accel_cr_mul_seq
  import accel_cr_responder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [7:0]     multiplicand,
  input  logic [7:0]     multiplier,
  input  logic           start_ready,
  input  logic           done_valid,
  output logic           start_valid,
  output stage_mul_inp_t mul_inp,
  output logic           busy,
  output logic           start_ack,
  output logic           result_we,
  output logic           timeout_hit
);

  t_mul_state state, state_nxt;
  logic       tmo_reached;

`ifdef ACCEL_CR_TIMEOUT_EN
  logic [7:0] wd_cnt;

  // Watchdog counts WAIT cycles; zero on every entry into WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              wd_cnt <= '0;
    else if (state != WAIT)  wd_cnt <= '0;
    else                     wd_cnt <= wd_cnt + 8'd1;
  end

  // Fires in the TIMEOUT_CYCLES-th consecutive WAIT cycle.
  assign tmo_reached = (wd_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_reached = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and one-cycle event strobes for the CR flops in the top.
  always_comb begin
    state_nxt   = state;
    start_ack   = 1'b0;
    result_we   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_ack = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (start_ready) state_nxt = WAIT;
      end
      WAIT: begin
        // A result arriving in the timeout cycle takes priority.
        if (done_valid) begin
          result_we = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_reached) begin
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are frozen at start so later CR_3/CR_4 writes cannot disturb REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_inp <= '0;
    end else if (start_ack) begin
      mul_inp.AQQ_0 <= {8'b0, multiplier, 1'b0};
      mul_inp.Mu    <= multiplicand;
    end
  end

  assign busy        = (state != IDLE);
  assign start_valid = (state == REQ);

endmodule

// File: rtl/accel_cr_responder.sv
// CR-space responder for the accel core: region decode, XOR and multiplier
// control registers, one-cycle read response, and the multiplier sequencer.
// Optional WAIT watchdog is enabled by defining ACCEL_CR_TIMEOUT_EN.
module accel_cr_responder
  import accel_cr_responder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                 Clk,
  input logic                 RstN,
  accel_cr_responder_if.slave bus
);

  logic        hit, wr, rd;
  logic        start, clr_done;
  logic [7:0]  xor_inp1, xor_inp2, xor_result;
  logic [7:0]  inp1_nxt, inp2_nxt;
  t_mul_cr     mul_cr;
  logic        busy, start_ack, result_we, timeout_hit;
  logic [31:0] rd_data;
  logic        unused_wdata;

  assign hit = bus.ReqValid &&
               (bus.ReqAddr >= CR_MEM_REGION_FLOOR) &&
               (bus.ReqAddr <= CR_MEM_REGION_ROOF);
  assign wr  = hit && bus.ReqWrEn;
  assign rd  = hit && !bus.ReqWrEn;

  assign start    = wr && (bus.ReqAddr == CR_MUL_CTRL) && bus.ReqWrData[CR5_START_BIT];
  assign clr_done = wr && (bus.ReqAddr == CR_MUL_CTRL) && bus.ReqWrData[CR5_CLR_DONE_BIT];

  // No CR is wider than a byte on the write side.
  assign unused_wdata = ^bus.ReqWrData[31:8];

  // Post-write XOR operands, so the result register tracks the same edge.
  always_comb begin
    inp1_nxt = xor_inp1;
    inp2_nxt = xor_inp2;
    if (wr && (bus.ReqAddr == CR_XOR_INP1)) inp1_nxt = bus.ReqWrData[7:0];
    if (wr && (bus.ReqAddr == CR_XOR_INP2)) inp2_nxt = bus.ReqWrData[7:0];
  end

  // XOR operand and result registers.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      xor_inp1   <= '0;
      xor_inp2   <= '0;
      xor_result <= '0;
    end else begin
      xor_inp1   <= inp1_nxt;
      xor_inp2   <= inp2_nxt;
      xor_result <= inp1_nxt ^ inp2_nxt;
    end
  end

  // Multiplier CRs; done is cleared by a new start, set by a captured
  // result (which beats a same-cycle clear), and cleared by software.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      mul_cr <= '0;
    end else begin
      if (wr && (bus.ReqAddr == CR_MUL_MCAND))  mul_cr.multiplicand <= bus.ReqWrData[7:0];
      if (wr && (bus.ReqAddr == CR_MUL_MPLIER)) mul_cr.multiplier   <= bus.ReqWrData[7:0];
      if (result_we)                            mul_cr.result       <= bus.MulResult;

      if (start_ack)      mul_cr.done <= 1'b0;
      else if (result_we) mul_cr.done <= 1'b1;
      else if (clr_done)  mul_cr.done <= 1'b0;

      if (start_ack)        mul_cr.timeout <= 1'b0;
      else if (timeout_hit) mul_cr.timeout <= 1'b1;
    end
  end

  // Read mux over pre-edge register values; unmapped addresses read 0.
  always_comb begin
    rd_data = '0;
    case (bus.ReqAddr)
      CR_XOR_INP1:   rd_data[7:0] = xor_inp1;
      CR_XOR_INP2:   rd_data[7:0] = xor_inp2;
      CR_XOR_RESULT: rd_data[7:0] = xor_result;
      CR_MUL_MCAND:  rd_data[7:0] = mul_cr.multiplicand;
      CR_MUL_MPLIER: rd_data[7:0] = mul_cr.multiplier;
      CR_MUL_CTRL: begin
        rd_data[CR5_BUSY_BIT]    = busy;
        rd_data[CR5_DONE_BIT]    = mul_cr.done;
        rd_data[CR5_TIMEOUT_BIT] = mul_cr.timeout;
      end
      CR_MUL_RESULT: rd_data[CR6_RESULT_MSB:CR6_RESULT_LSB] = mul_cr.result;
      default:       rd_data = '0;
    endcase
  end

  // One-cycle read response.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      bus.RspValid <= 1'b0;
      bus.RspData  <= '0;
    end else begin
      bus.RspValid <= rd;
      bus.RspData  <= rd ? rd_data : 32'd0;
    end
  end

  accel_cr_mul_seq #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_mul_seq (
    .clk          (Clk),
    .rst_n        (RstN),
    .start        (start),
    .multiplicand (mul_cr.multiplicand),
    .multiplier   (mul_cr.multiplier),
    .start_ready  (bus.MulStartReady),
    .done_valid   (bus.MulDoneValid),
    .start_valid  (bus.MulStartValid),
    .mul_inp      (bus.MulInp),
    .busy         (busy),
    .start_ack    (start_ack),
    .result_we    (result_we),
    .timeout_hit  (timeout_hit)
  );

endmodule

// File: tb/tb_accel_cr_responder.sv
// Directed bench for accel_cr_responder (watchdog scenario only when
// ACCEL_CR_TIMEOUT_EN is defined).
module tb_accel_cr_responder;
  import accel_cr_responder_pkg::*;

  logic Clk = 1'b0;
  logic RstN;
  int   total = 0;
  int   bad   = 0;

  accel_cr_responder_if bus();

  accel_cr_responder #(.TIMEOUT_CYCLES(10)) dut (
    .Clk  (Clk),
    .RstN (RstN),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached, want test completion");
    $fatal(1, "bench time limit");
  end

  task automatic idle_cycle();
    @(posedge Clk); #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    bus.ReqValid = 1'b1; bus.ReqWrEn = 1'b1; bus.ReqAddr = addr; bus.ReqWrData = data;
    @(posedge Clk); #1;
    bus.ReqValid = 1'b0; bus.ReqWrEn = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic vld, output logic [31:0] data);
    bus.ReqValid = 1'b1; bus.ReqWrEn = 1'b0; bus.ReqAddr = addr;
    @(posedge Clk); #1;
    bus.ReqValid = 1'b0;
    vld  = bus.RspValid;
    data = bus.RspData;
  endtask

  task automatic test_reset();
    logic        v;
    logic [31:0] d;
    logic [31:0] addrs [7];
    addrs = '{CR_XOR_INP1, CR_XOR_INP2, CR_XOR_RESULT, CR_MUL_MCAND,
              CR_MUL_MPLIER, CR_MUL_CTRL, CR_MUL_RESULT};
    RstN = 1'b0;
    bus.ReqValid = 0; bus.ReqWrEn = 0; bus.ReqAddr = 0; bus.ReqWrData = 0;
    bus.MulStartReady = 0; bus.MulDoneValid = 0; bus.MulResult = 0;
    #12;
    total++;
    if (bus.RspValid !== 1'b0 || bus.RspData !== 32'd0 ||
        bus.MulStartValid !== 1'b0 || bus.MulInp !== 25'd0) begin
      bad++;
      $display("FAIL reset_outputs: got rv=%b rd=%h sv=%b inp=%h, want all 0",
               bus.RspValid, bus.RspData, bus.MulStartValid, bus.MulInp);
    end
    RstN = 1'b1;
    idle_cycle();
    for (int i = 0; i < 7; i++) begin
      do_read(addrs[i], v, d);
      total++;
      if (v !== 1'b1 || d !== 32'd0) begin
        bad++;
        $display("FAIL reset_cr%0d: got vld=%b data=%h, want vld=1 data=0", i, v, d);
      end
    end
  endtask

  task automatic test_xor();
    logic        v;
    logic [31:0] d;
    do_write(CR_XOR_INP1, 32'h0000_00A5);
    do_read(CR_XOR_INP1, v, d);
    total++;
    if (v !== 1'b1 || d !== 32'h0000_00A5) begin
      bad++; $display("FAIL raw_cr0: got vld=%b data=%h, want 1/000000a5", v, d);
    end
    do_write(CR_XOR_INP2, 32'hFFFF_FF3C);
    do_read(CR_XOR_RESULT, v, d);
    total++;
    if (v !== 1'b1 || d !== 32'h0000_0099) begin
      bad++; $display("FAIL xor_result: got vld=%b data=%h, want 1/00000099", v, d);
    end
    idle_cycle();
    total++;
    if (bus.RspValid !== 1'b0) begin
      bad++; $display("FAIL rsp_one_cycle: got vld=%b, want 0", bus.RspValid);
    end
  endtask

  task automatic test_back_to_back();
    bus.ReqValid = 1'b1; bus.ReqWrEn = 1'b0; bus.ReqAddr = CR_XOR_INP1;
    @(posedge Clk); #1;
    bus.ReqAddr = CR_XOR_INP2;
    total++;
    if (bus.RspValid !== 1'b1 || bus.RspData !== 32'h0000_00A5) begin
      bad++; $display("FAIL b2b_first: got vld=%b data=%h, want 1/000000a5", bus.RspValid, bus.RspData);
    end
    @(posedge Clk); #1;
    bus.ReqValid = 1'b0;
    total++;
    if (bus.RspValid !== 1'b1 || bus.RspData !== 32'h0000_003C) begin
      bad++; $display("FAIL b2b_second: got vld=%b data=%h, want 1/0000003c", bus.RspValid, bus.RspData);
    end
  endtask

  task automatic test_mul();
    logic        v;
    logic [31:0] d;
    bus.MulStartReady = 1'b1;
    do_write(CR_MUL_MCAND, 32'd7);
    do_write(CR_MUL_MPLIER, 32'd9);
    do_write(CR_MUL_CTRL, 32'd1);
    total++;
    if (bus.MulStartValid !== 1'b1 || bus.MulInp !== {17'h00012, 8'h07}) begin
      bad++; $display("FAIL mul_start: got sv=%b inp=%h, want 1/%h", bus.MulStartValid, bus.MulInp, {17'h00012, 8'h07});
    end
    idle_cycle();
    total++;
    if (bus.MulStartValid !== 1'b0) begin
      bad++; $display("FAIL mul_wait_sv: got sv=%b, want 0", bus.MulStartValid);
    end
    bus.MulDoneValid = 1'b1; bus.MulResult = 16'd63;
    do_read(CR_MUL_CTRL, v, d);
    bus.MulDoneValid = 1'b0;
    total++;
    if (v !== 1'b1 || d !== 32'h1) begin
      bad++; $display("FAIL status_pre_done: got vld=%b data=%h, want 1/00000001", v, d);
    end
    do_read(CR_MUL_CTRL, v, d);
    total++;
    if (d !== 32'h2) begin
      bad++; $display("FAIL status_done: got %h, want 00000002", d);
    end
    do_read(CR_MUL_RESULT, v, d);
    total++;
    if (d !== 32'd63) begin
      bad++; $display("FAIL mul_result: got %h, want 0000003f", d);
    end
    // clear-done in the same cycle as the result strobe: done must stay set
    do_write(CR_MUL_CTRL, 32'd1);
    idle_cycle();
    bus.MulDoneValid = 1'b1; bus.MulResult = 16'h0055;
    do_write(CR_MUL_CTRL, 32'd2);
    bus.MulDoneValid = 1'b0;
    do_read(CR_MUL_CTRL, v, d);
    total++;
    if (d !== 32'h2) begin
      bad++; $display("FAIL done_wins: got %h, want 00000002", d);
    end
    do_write(CR_MUL_CTRL, 32'd2);
    do_read(CR_MUL_CTRL, v, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL done_clear: got %h, want 00000000", d);
    end
  endtask

  task automatic test_stall();
    logic        v;
    logic [31:0] d;
    bus.MulStartReady = 1'b0;
    do_write(CR_MUL_CTRL, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1)      do_write(CR_MUL_MCAND, 32'hFF);
      else if (i == 2) do_write(CR_MUL_CTRL, 32'd1);
      else             idle_cycle();
      total++;
      if (bus.MulStartValid !== 1'b1 || bus.MulInp !== {17'h00012, 8'h07}) begin
        bad++; $display("FAIL stall_c%0d: got sv=%b inp=%h, want 1/%h", i, bus.MulStartValid, bus.MulInp, {17'h00012, 8'h07});
      end
    end
    do_read(CR_MUL_CTRL, v, d);
    total++;
    if (d !== 32'h1) begin
      bad++; $display("FAIL stall_busy: got %h, want 00000001", d);
    end
    bus.MulStartReady = 1'b1;
    idle_cycle();
    bus.MulDoneValid = 1'b1; bus.MulResult = 16'h1234;
    idle_cycle();
    bus.MulDoneValid = 1'b0;
    do_read(CR_MUL_RESULT, v, d);
    total++;
    if (d !== 32'h1234) begin
      bad++; $display("FAIL stall_result: got %h, want 00001234", d);
    end
    do_read(CR_MUL_MCAND, v, d);
    total++;
    if (d !== 32'hFF) begin
      bad++; $display("FAIL busy_cr3_write: got %h, want 000000ff", d);
    end
  endtask

  task automatic test_decode();
    logic        v;
    logic [31:0] d;
    do_read(32'h0100_0000, v, d);
    total++;
    if (v !== 1'b0) begin
      bad++; $display("FAIL out_of_region: got vld=%b, want 0", v);
    end
    do_read(32'h00FE_0300, v, d);
    total++;
    if (v !== 1'b1 || d !== 32'd0) begin
      bad++; $display("FAIL unmapped_read: got vld=%b data=%h, want 1/0", v, d);
    end
    do_write(CR_MUL_RESULT, 32'hFFFF);
    do_write(CR_XOR_RESULT, 32'h0);
    do_write(32'h0100_0000, 32'h11);
    bus.MulDoneValid = 1'b1; bus.MulResult = 16'hBEEF;
    idle_cycle();
    bus.MulDoneValid = 1'b0;
    do_read(CR_MUL_RESULT, v, d);
    total++;
    if (d !== 32'h1234) begin
      bad++; $display("FAIL ro_cr6: got %h, want 00001234", d);
    end
    do_read(CR_XOR_RESULT, v, d);
    total++;
    if (d !== 32'h99) begin
      bad++; $display("FAIL ro_cr2: got %h, want 00000099", d);
    end
    do_read(CR_XOR_INP1, v, d);
    total++;
    if (d !== 32'hA5) begin
      bad++; $display("FAIL nonhit_write: got %h, want 000000a5", d);
    end
  endtask

  task automatic test_reset_mid();
    logic        v;
    logic [31:0] d;
    bus.MulStartReady = 1'b1;
    do_write(CR_MUL_CTRL, 32'd1);
    idle_cycle();
    bus.ReqValid = 1'b1; bus.ReqWrEn = 1'b0; bus.ReqAddr = CR_XOR_INP1;
    @(posedge Clk); #1;
    bus.ReqValid = 1'b0;
    total++;
    if (bus.RspValid !== 1'b1 || bus.MulInp !== {17'h00012, 8'hFF}) begin
      bad++; $display("FAIL pre_reset: got rv=%b inp=%h, want 1/%h", bus.RspValid, bus.MulInp, {17'h00012, 8'hFF});
    end
    #2 RstN = 1'b0;
    #1;
    total++;
    if (bus.RspValid !== 1'b0 || bus.RspData !== 32'd0 ||
        bus.MulStartValid !== 1'b0 || bus.MulInp !== 25'd0) begin
      bad++;
      $display("FAIL async_reset: got rv=%b rd=%h sv=%b inp=%h, want all 0",
               bus.RspValid, bus.RspData, bus.MulStartValid, bus.MulInp);
    end
    #2 RstN = 1'b1;
    idle_cycle();
    bus.MulDoneValid = 1'b1; bus.MulResult = 16'h7777;
    idle_cycle();
    bus.MulDoneValid = 1'b0;
    do_read(CR_MUL_CTRL, v, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL post_reset_status: got %h, want 00000000", d);
    end
    do_read(CR_MUL_RESULT, v, d);
    total++;
    if (d !== 32'h0) begin
      bad++; $display("FAIL post_reset_result: got %h, want 00000000", d);
    end
  endtask

`ifdef ACCEL_CR_TIMEOUT_EN
  task automatic test_timeout();
    logic        v;
    logic [31:0] d;
    bus.MulStartReady = 1'b1;
    do_write(CR_MUL_CTRL, 32'd1);
    for (int i = 0; i < 11; i++) idle_cycle();
    do_read(CR_MUL_CTRL, v, d);
    total++;
    if (d !== 32'h4) begin
      bad++; $display("FAIL timeout_status: got %h, want 00000004", d);
    end
    do_write(CR_MUL_CTRL, 32'd1);
    total++;
    if (bus.MulStartValid !== 1'b1) begin
      bad++; $display("FAIL restart_after_timeout: got sv=%b, want 1", bus.MulStartValid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_xor();
    test_back_to_back();
    test_mul();
    test_stall();
    test_decode();
    test_reset_mid();
`ifdef ACCEL_CR_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
